// File: rtl/hex_display_bank_if.sv
// hex_display_bank_if: digit values, display controls and segment outputs for the display bank.
interface hex_display_bank_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic [DIGITS-1:0]   blank_mask;
  logic [DIGITS-1:0]   blink_en;
  logic                lz_blank;
  logic                lamp_test;
  logic [7*DIGITS-1:0] HEX;
  modport master (output value, load, blank_mask, blink_en, lz_blank, lamp_test, input HEX);
  modport slave  (input value, load, blank_mask, blink_en, lz_blank, lamp_test, output HEX);
endinterface

// File: rtl/hex_display_bank.sv
// hex_display_bank: registered multi-digit active-low seven-segment driver
// with blanking, blinking, leading-zero suppression and lamp test.
module hex_display_bank #(
  parameter int DIGITS    = 4,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                    clk,
  input  logic                    Reset,
  hex_display_bank_if.slave       bus
);
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [4*DIGITS-1:0] r_val;
  logic [CW-1:0]       r_cnt;
  logic                r_blink_off;
  logic [7*DIGITS-1:0] r_hex;
  logic [7*DIGITS-1:0] w_next;
  logic [DIGITS-1:0]   w_lz;
  logic                w_acc;
  logic                w_wrap;
  assign w_wrap = r_cnt == LAST;
  // Scan from the top digit down; suppression stops at the first nonzero digit.
  always_comb begin
    w_lz  = '0;
    w_acc = bus.lz_blank;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_acc   = w_acc & (r_val[4*k+:4] == 4'd0);
      w_lz[k] = w_acc;
    end
  end
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign w_next[7*g+:7] = bus.lamp_test ? 7'b0000000 :
                            (bus.blank_mask[g] | w_lz[g] | (bus.blink_en[g] & r_blink_off)) ? 7'b1111111 :
                            GLYPH[r_val[4*g+:4]];
  end
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_val       <= '0;
      r_cnt       <= '0;
      r_blink_off <= 1'b0;
      r_hex       <= {DIGITS{7'b1000000}};
    end else begin
      if (bus.load) r_val <= bus.value;
      r_cnt       <= w_wrap ? '0 : r_cnt + CW'(1);
      r_blink_off <= r_blink_off ^ w_wrap;
      r_hex       <= w_next;
    end
  end
  assign bus.HEX = r_hex;
endmodule

// File: tb/tb_hex_display_bank.sv
// tb_hex_display_bank: directed and random checks of hex_display_bank against a cycle-count reference model.
module tb_hex_display_bank;
  localparam int D  = 4;
  localparam int BD = 4;
  localparam logic [6:0] GL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] DK = 7'b1111111;
  logic clk = 1'b0;
  logic Reset = 1'b0;
  int total = 0;
  int bad = 0;
  logic [15:0] m_val = '0;
  int m_n = 0;
  always #5 clk = ~clk;
  hex_display_bank_if #(.DIGITS(D)) bus ();
  hex_display_bank #(.DIGITS(D), .BLINK_DIV(BD)) dut (.clk(clk), .Reset(Reset), .bus(bus));
  function automatic logic [27:0] model_hex();
    logic [27:0] h;
    logic off;
    off = ((m_n / BD) % 2) == 1;
    for (int i = 0; i < D; i++) begin
      if (bus.lamp_test) h[7*i+:7] = 7'b0000000;
      else if (bus.blank_mask[i] || (bus.lz_blank && i > 0 && (m_val >> (4*i)) == 0) || (bus.blink_en[i] && off))
        h[7*i+:7] = DK;
      else h[7*i+:7] = GL[m_val[4*i+:4]];
    end
    return h;
  endfunction
  task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: HEX=%h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input string tag);
    logic [27:0] exp;
    exp = Reset ? model_hex() : {D{7'b1000000}};
    if (!Reset) begin
      m_val = '0;
      m_n   = 0;
    end else begin
      if (bus.load) m_val = bus.value;
      m_n++;
    end
    @(posedge clk);
    #1;
    check(tag, bus.HEX, exp);
  endtask
  initial begin
    bus.value = '0; bus.load = 0; bus.blank_mask = '0; bus.blink_en = '0;
    bus.lz_blank = 0; bus.lamp_test = 1;
    repeat (3) tick("reset");
    check("reset_const", bus.HEX, {4{7'b1000000}});
    Reset = 1; bus.lamp_test = 0;
    repeat (3) tick("release");
    check("release_0000", bus.HEX, {4{7'b1000000}});
    bus.value = 16'h9A3F; bus.load = 1; tick("load1");
    bus.load = 0; tick("load2");
    check("glyph_9A3F", bus.HEX, {7'b0010000, 7'b0001000, 7'b0110000, 7'b0001110});
    bus.value = 16'h1111; tick("hold1"); tick("hold2");
    check("hold_9A3F", bus.HEX, {7'b0010000, 7'b0001000, 7'b0110000, 7'b0001110});
    bus.lz_blank = 1; bus.value = 16'h0050; bus.load = 1; tick("lz1");
    bus.load = 0; tick("lz2");
    check("lz_0050", bus.HEX, {DK, DK, 7'b0010010, 7'b1000000});
    bus.value = 16'h0000; bus.load = 1; tick("lz3");
    bus.load = 0; tick("lz4");
    check("lz_0000", bus.HEX, {DK, DK, DK, 7'b1000000});
    bus.lz_blank = 0;
    bus.blank_mask = 4'b0001; bus.lamp_test = 1; tick("prio1");
    check("prio_lamp", bus.HEX, 28'd0);
    bus.lamp_test = 0; tick("prio2");
    check("prio_mask", bus.HEX, {7'b1000000, 7'b1000000, 7'b1000000, DK});
    bus.blank_mask = '0;
    Reset = 0; bus.value = 16'h1234; bus.load = 1; bus.blink_en = 4'b0010; tick("blink_rst");
    Reset = 1; tick("blink_e1");
    bus.load = 0;
    for (int k = 2; k <= 12; k++) begin
      tick("blink");
      check("blink_phase", bus.HEX,
            {7'b1111001, 7'b0100100, (k >= 5 && k <= 8) ? DK : 7'b0110000, 7'b0011001});
    end
    Reset = 0; bus.value = 16'hFFFF; bus.load = 1; tick("rst_mid");
    check("rst_mid_const", bus.HEX, {4{7'b1000000}});
    Reset = 1; bus.load = 0;
    for (int k = 1; k <= 5; k++) begin
      tick("restart");
      check("restart_phase", bus.HEX,
            {7'b1000000, 7'b1000000, (k == 5) ? DK : 7'b1000000, 7'b1000000});
    end
    bus.blink_en = '0;
    for (int n = 0; n < 400; n++) begin
      Reset          = $urandom_range(0, 24) != 0;
      bus.value      = 16'($urandom);
      bus.load       = $urandom_range(0, 2) == 0;
      bus.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      bus.blink_en   = 4'($urandom);
      bus.lz_blank   = 1'($urandom);
      bus.lamp_test  = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 1) == 0) bus.value = bus.value & 16'h00FF;
      tick("random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
